// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/len/payload/checksum frames from uart_rx and
// streams little-endian 32-bit words into the ICCM, holding the core in reset meanwhile.
module uart_boot_loader #(
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned MaxWords      = 4096,
    parameter int unsigned TimeoutCycles = 1000000,
    parameter logic [7:0]  SyncByte      = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_byte_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic                 hold_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [AddrWidth:0]   words_o
);

    localparam int unsigned WIDX = AddrWidth + 1;
    localparam int unsigned TW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} state_t;

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [7:0]           csum_q, csum_d;
    logic [1:0]           bidx_q, bidx_d;
    logic [23:0]          word_q, word_d;
    logic [WIDX-1:0]      words_q, words_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 hold_q, hold_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 fail;
    logic [7:0]           csum_add;
    logic [15:0]          len_full;
    logic [WIDX-1:0]      words_inc;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        csum_d    = csum_q;
        bidx_d    = bidx_q;
        word_d    = word_q;
        words_d   = words_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        fail      = 1'b0;
        csum_add  = csum_q + rx_byte_i;
        len_full  = {rx_byte_i, len_q[7:0]};
        words_inc = words_q + WIDX'(1);

        // A byte arriving on the terminal count wins over the timeout.
        if (state_q != IDLE) begin
            if (rx_dv_i)                tmo_d = '0;
            else if (tmo_q == TmoLast)  fail  = 1'b1;
            else                        tmo_d = tmo_q + TW'(1);
        end

        if (rx_dv_i) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte_i == SyncByte) begin
                        state_d = LEN_LO;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        words_d = '0;
                        csum_d  = '0;
                        hold_d  = 1'b1;
                        tmo_d   = '0;
                    end
                end
                LEN_LO: begin
                    len_d[7:0] = rx_byte_i;
                    csum_d     = csum_add;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d  = len_full;
                    csum_d = csum_add;
                    if (len_full == 16'd0 || 32'(len_full) > MaxWords) begin
                        fail = 1'b1;
                    end else begin
                        state_d = DATA;
                        words_d = '0;
                        bidx_d  = '0;
                    end
                end
                DATA: begin
                    csum_d = csum_add;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: word_d[7:0]   = rx_byte_i;
                        2'd1: word_d[15:8]  = rx_byte_i;
                        2'd2: word_d[23:16] = rx_byte_i;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = words_q[AddrWidth-1:0];
                            wdata_d = {rx_byte_i, word_q};
                            words_d = words_inc;
                            if (words_inc == WIDX'(len_q)) state_d = CSUM;
                        end
                    endcase
                end
                CSUM: begin
                    if (csum_add == 8'd0) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Written words stay in place; only the status reflects the failure.
        if (fail) begin
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            words_q <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign hold_o  = hold_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign words_o = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frame parsing, checksum, length, timeout and reset cases.
module tb_uart_boot_loader;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          rx_dv_i;
    logic [7:0]    rx_byte_i;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          hold_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   words_o;

    int checks   = 0;
    int failures = 0;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wlog[$];

    uart_boot_loader #(
        .AddrWidth(AW), .MaxWords(4096), .TimeoutCycles(16), .SyncByte(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
        .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .hold_o(hold_o),
        .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (we_o) wlog.push_back('{addr_o, wdata_o});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
        if (idx < wlog.size()) begin
            check({tag, "_addr"}, 64'(wlog[idx].a), 64'(a));
            check({tag, "_data"}, 64'(wlog[idx].d), 64'(d));
        end else begin
            check({tag, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold,
                                input int words);
        check({tag, "_done"},  64'(done_o),  64'(done));
        check({tag, "_err"},   64'(err_o),   64'(err));
        check({tag, "_hold"},  64'(hold_o),  64'(hold));
        check({tag, "_words"}, 64'(words_o), 64'(words));
    endtask

    // Back-to-back bytes; returns at the negedge after the last byte's edge.
    task automatic send(input bytes_t bs);
        foreach (bs[i]) begin
            @(negedge clock);
            rx_dv_i   = 1'b1;
            rx_byte_i = bs[i];
        end
        @(negedge clock);
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
        idle(3);
        check("rst_we",    64'(we_o),    64'd0);
        check("rst_addr",  64'(addr_o),  64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        idle(2);

        // 1: good 2-word frame
        wlog.delete();
        send('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A});
        idle(2);
        check("t1_nwr", 64'(wlog.size()), 64'd2);
        check_wr("t1_w0", 0, 12'd0, 32'h44332211);
        check_wr("t1_w1", 1, 12'd1, 32'h88776655);
        check_status("t1", 1'b1, 1'b0, 1'b0, 2);

        // 2: bad checksum, words still written
        wlog.delete();
        send('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9B});
        idle(2);
        check("t2_nwr", 64'(wlog.size()), 64'd2);
        check_wr("t2_w0", 0, 12'd0, 32'h44332211);
        check_wr("t2_w1", 1, 12'd1, 32'h88776655);
        check_status("t2", 1'b0, 1'b1, 1'b1, 2);

        // 3: length 0 and length 4097
        wlog.delete();
        send('{8'hA5, 8'h00});
        check("t3a_err_mid", 64'(err_o), 64'd0);
        send('{8'h00});
        check("t3a_err", 64'(err_o), 64'd1);
        check("t3a_hold", 64'(hold_o), 64'd1);
        send('{8'hA5, 8'h01});
        check("t3b_err_mid", 64'(err_o), 64'd0);
        send('{8'h10});
        check("t3b_err", 64'(err_o), 64'd1);
        check("t3b_done", 64'(done_o), 64'd0);
        idle(2);
        check("t3_nwr", 64'(wlog.size()), 64'd0);

        // 4: timeout at the 16th idle cycle, then a good frame
        wlog.delete();
        send('{8'hA5, 8'h01, 8'h00, 8'hEF});
        idle(15);
        check("t4_err_pre", 64'(err_o), 64'd0);
        idle(1);
        check("t4_err_tmo", 64'(err_o), 64'd1);
        check("t4_hold_tmo", 64'(hold_o), 64'd1);
        check("t4_nwr_tmo", 64'(wlog.size()), 64'd0);
        send('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7});
        idle(2);
        check("t4_nwr", 64'(wlog.size()), 64'd1);
        check_wr("t4_w0", 0, 12'd0, 32'hDEADBEEF);
        check_status("t4", 1'b1, 1'b0, 1'b0, 1);

        // 5: garbage before a frame leaves status alone
        wlog.delete();
        send('{8'h00, 8'hFF, 8'h5A});
        idle(2);
        check_status("t5_gb", 1'b1, 1'b0, 1'b0, 1);
        check("t5_nwr_gb", 64'(wlog.size()), 64'd0);
        send('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB});
        idle(2);
        check("t5_nwr", 64'(wlog.size()), 64'd1);
        check_wr("t5_w0", 0, 12'd0, 32'h12345678);
        check_status("t5", 1'b1, 1'b0, 1'b0, 1);

        // 6: reset mid-frame
        wlog.delete();
        send('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE});
        check("t6_hold_pre", 64'(hold_o), 64'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_status("t6_rst", 1'b0, 1'b0, 1'b0, 0);
        check("t6_addr", 64'(addr_o), 64'd0);
        check("t6_wdata", 64'(wdata_o), 64'd0);
        send('{8'hAD, 8'hDE, 8'hC7});
        idle(20);
        check("t6_nwr_rst", 64'(wlog.size()), 64'd0);
        check_status("t6_stray", 1'b0, 1'b0, 1'b0, 0);
        send('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7});
        idle(2);
        check("t6_nwr", 64'(wlog.size()), 64'd1);
        check_wr("t6_w0", 0, 12'd0, 32'hDEADBEEF);
        check_status("t6", 1'b1, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
